// File: rtl/cv32e40p_x_alu_responder.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_alu_responder
// Coprocessor-side X-interface responder for cv32e40p. It decodes custom-0
// instructions (opcode 7'h0B, funct7 0) and runs one of a few integer ALU ops
// through a fixed-latency pipeline. Results return in program order through a
// response FIFO that honours core backpressure.
//
// Optional feature macro: X_ALU_ERR_EN
//   defined   : funct3=111 is accepted with no operand requirement and answers
//               with x_p_error_o=1, x_p_data_o=0.
//   undefined : funct3=111 is rejected like any other unknown encoding.
//
// Operand packing on x_q_rs_i: rs1=[31:0], rs2=[63:32], rs3=[95:64].
// -----------------------------------------------------------------------------
module cv32e40p_x_alu_responder #(
    parameter int LATENCY    = 2,   // accept -> FIFO write, legal 1..8
    parameter int FIFO_DEPTH = 4    // response entries / max outstanding, legal 2..16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        x_q_valid_i,
    output logic        x_q_ready_o,
    input  logic [31:0] x_q_instr_data_i,
    input  logic [95:0] x_q_rs_i,
    input  logic [2:0]  x_q_rs_valid_i,
    input  logic        x_q_rd_clean_i,

    output logic        x_k_accept_o,
    output logic        x_k_is_mem_op_o,
    output logic        x_k_writeback_o,

    output logic        x_p_valid_o,
    input  logic        x_p_ready_i,
    output logic [4:0]  x_p_rd_o,
    output logic [31:0] x_p_data_o,
    output logic        x_p_dualwb_o,
    output logic        x_p_type_o,
    output logic        x_p_error_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [6:0]       OPC_CUSTOM0 = 7'h0B;

    // ------------------------------------------------------------------
    // Request field extraction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic        unused_instr_bits;

    assign opcode   = x_q_instr_data_i[6:0];
    assign rd_field = x_q_instr_data_i[11:7];
    assign funct3   = x_q_instr_data_i[14:12];
    assign funct7   = x_q_instr_data_i[31:25];
    assign rs1      = x_q_rs_i[31:0];
    assign rs2      = x_q_rs_i[63:32];
    assign rs3      = x_q_rs_i[95:64];

    // Register-index fields are irrelevant: operands arrive by value.
    assign unused_instr_bits = ^x_q_instr_data_i[24:15];

    // ------------------------------------------------------------------
    // ALU datapath (evaluated on the request operands, result is piped)
    // ------------------------------------------------------------------
    logic [31:0] madd_res;
    logic [31:0] add_res;
    logic [31:0] xor_res;
    logic [31:0] min_res;

    assign madd_res = (rs1 * rs2) + rs3;
    assign add_res  = rs1 + rs2;
    assign xor_res  = rs1 ^ rs2;
    assign min_res  = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;

    // ------------------------------------------------------------------
    // State declarations
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] credits;

    logic [LATENCY-1:0] pipe_valid;
    logic [4:0]         pipe_rd   [LATENCY];
    logic [31:0]        pipe_data [LATENCY];
    logic               pipe_err  [LATENCY];

    logic [4:0]         fifo_rd   [FIFO_DEPTH];
    logic [31:0]        fifo_data [FIFO_DEPTH];
    logic               fifo_err  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    // ------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------
    logic        op_known;
    logic        op_operands_ok;
    logic [31:0] op_result;
    logic        op_error;
    logic        q_ready;
    logic        offload;
    logic        push;
    logic        pop;

    // Decode the offered instruction: legality, operand needs and result.
    always_comb begin
        op_known       = 1'b0;
        op_operands_ok = 1'b0;
        op_result      = 32'h0000_0000;
        op_error       = 1'b0;
        if ((opcode == OPC_CUSTOM0) && (funct7 == 7'd0)) begin
            case (funct3)
                3'b000: begin
                    op_known       = 1'b1;
                    op_operands_ok = (x_q_rs_valid_i == 3'b111);
                    op_result      = madd_res;
                end
                3'b001: begin
                    op_known       = 1'b1;
                    op_operands_ok = (x_q_rs_valid_i[1:0] == 2'b11);
                    op_result      = add_res;
                end
                3'b010: begin
                    op_known       = 1'b1;
                    op_operands_ok = (x_q_rs_valid_i[1:0] == 2'b11);
                    op_result      = xor_res;
                end
                3'b011: begin
                    op_known       = 1'b1;
                    op_operands_ok = (x_q_rs_valid_i[1:0] == 2'b11);
                    op_result      = min_res;
                end
`ifdef X_ALU_ERR_EN
                3'b111: begin
                    op_known       = 1'b1;
                    op_operands_ok = 1'b1;
                    op_result      = 32'h0000_0000;
                    op_error       = 1'b1;
                end
`endif
                default: begin
                    op_known       = 1'b0;
                    op_operands_ok = 1'b0;
                    op_result      = 32'h0000_0000;
                    op_error       = 1'b0;
                end
            endcase
        end else begin
            op_known = 1'b0;
        end
    end

    // Ready: unknown encodings are consumed at once (and rejected); known
    // ops wait for operands, a clean rd and a free response credit.
    always_comb begin
        q_ready = 1'b0;
        if (rst_i) begin
            q_ready = 1'b0;
        end else if (!op_known) begin
            q_ready = 1'b1;
        end else begin
            q_ready = op_operands_ok && x_q_rd_clean_i && (credits < CNT_FULL);
        end
    end

    assign offload = x_q_valid_i && q_ready && op_known;
    assign push    = pipe_valid[LATENCY-1];
    assign pop     = (fifo_count != {CNT_W{1'b0}}) && x_p_ready_i;

    assign x_q_ready_o     = q_ready;
    assign x_k_accept_o    = offload;
    assign x_k_writeback_o = offload;
    assign x_k_is_mem_op_o = 1'b0;

    // Credit counter: outstanding = in pipeline + waiting in the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits <= {CNT_W{1'b0}};
        end else begin
            case ({offload, pop})
                2'b10:   credits <= credits + CNT_W'(1);
                2'b01:   credits <= credits - CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Fixed-latency result pipeline; never stalls, flushed by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                pipe_rd[i]   <= 5'd0;
                pipe_data[i] <= 32'h0000_0000;
                pipe_err[i]  <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= offload;
            pipe_rd[0]    <= rd_field;
            pipe_data[0]  <= op_result;
            pipe_err[0]   <= op_error;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rd[i]    <= pipe_rd[i-1];
                pipe_data[i]  <= pipe_data[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    // Response FIFO: circular buffer with modulo-depth pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= {PTR_W{1'b0}};
            rd_ptr     <= {PTR_W{1'b0}};
            fifo_count <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd[i]   <= 5'd0;
                fifo_data[i] <= 32'h0000_0000;
                fifo_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= pipe_rd[LATENCY-1];
                fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
                fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
                wr_ptr <= (wr_ptr == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr + PTR_W'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr + PTR_W'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Response channel is driven straight from FIFO state (head entry).
    assign x_p_valid_o  = (fifo_count != {CNT_W{1'b0}});
    assign x_p_rd_o     = fifo_rd[rd_ptr];
    assign x_p_data_o   = fifo_data[rd_ptr];
    assign x_p_error_o  = fifo_err[rd_ptr];
    assign x_p_dualwb_o = 1'b0;
    assign x_p_type_o   = 1'b0;

endmodule

// File: tb/tb_cv32e40p_x_alu_responder.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_x_alu_responder
// Directed self-checking bench for cv32e40p_x_alu_responder (LATENCY=2,
// FIFO_DEPTH=4). Inputs change on the falling edge; outputs are checked #1
// after that, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cv32e40p_x_alu_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_q_valid_i;
    logic        x_q_ready_o;
    logic [31:0] x_q_instr_data_i;
    logic [95:0] x_q_rs_i;
    logic [2:0]  x_q_rs_valid_i;
    logic        x_q_rd_clean_i;
    logic        x_k_accept_o;
    logic        x_k_is_mem_op_o;
    logic        x_k_writeback_o;
    logic        x_p_valid_o;
    logic        x_p_ready_i;
    logic [4:0]  x_p_rd_o;
    logic [31:0] x_p_data_o;
    logic        x_p_dualwb_o;
    logic        x_p_type_o;
    logic        x_p_error_o;

    int checks = 0;
    int errors = 0;

    cv32e40p_x_alu_responder #(
        .LATENCY    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .x_q_valid_i      (x_q_valid_i),
        .x_q_ready_o      (x_q_ready_o),
        .x_q_instr_data_i (x_q_instr_data_i),
        .x_q_rs_i         (x_q_rs_i),
        .x_q_rs_valid_i   (x_q_rs_valid_i),
        .x_q_rd_clean_i   (x_q_rd_clean_i),
        .x_k_accept_o     (x_k_accept_o),
        .x_k_is_mem_op_o  (x_k_is_mem_op_o),
        .x_k_writeback_o  (x_k_writeback_o),
        .x_p_valid_o      (x_p_valid_o),
        .x_p_ready_i      (x_p_ready_i),
        .x_p_rd_o         (x_p_rd_o),
        .x_p_data_o       (x_p_data_o),
        .x_p_dualwb_o     (x_p_dualwb_o),
        .x_p_type_o       (x_p_type_o),
        .x_p_error_o      (x_p_error_o)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 10'd0, f3, rd, opc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
        x_q_instr_data_i = instr;
        x_q_rs_i         = {c, b, a};
        x_q_valid_i      = 1'b1;
    endtask

    initial begin
        int seen;

        // ---------------- reset state ----------------
        rst_i          = 1'b1;
        x_p_ready_i    = 1'b0;
        x_q_rs_valid_i = 3'b111;
        x_q_rd_clean_i = 1'b1;
        req(enc(7'd0, 3'b001, 5'd1, 7'h0B), 32'd1, 32'd2, 32'd3);
        @(negedge clk_i);
        check("rst_ready",    x_q_ready_o, 32'd0);
        check("rst_accept",   x_k_accept_o, 32'd0);
        check("rst_wb",       x_k_writeback_o, 32'd0);
        check("rst_pvalid",   x_p_valid_o, 32'd0);
        check("rst_rd",       x_p_rd_o, 32'd0);
        check("rst_data",     x_p_data_o, 32'd0);
        check("rst_err",      x_p_error_o, 32'd0);
        check("const_memop",  x_k_is_mem_op_o, 32'd0);
        check("const_dualwb", x_p_dualwb_o, 32'd0);
        check("const_type",   x_p_type_o, 32'd0);
        rst_i       = 1'b0;
        x_q_valid_i = 1'b0;
        x_p_ready_i = 1'b1;
        @(negedge clk_i);

        // ---------------- 1: ADD wrap, exact latency ----------------
        x_q_rs_valid_i = 3'b011;
        req(enc(7'd0, 3'b001, 5'd5, 7'h0B), 32'hFFFF_FFFF, 32'd1, 32'd0);
        #1;
        check("t1_ready",  x_q_ready_o, 32'd1);
        check("t1_accept", x_k_accept_o, 32'd1);
        check("t1_wb",     x_k_writeback_o, 32'd1);
        @(negedge clk_i);
        x_q_valid_i = 1'b0;
        #1;
        check("t1_lat1", x_p_valid_o, 32'd0);
        @(negedge clk_i);
        check("t1_lat2", x_p_valid_o, 32'd0);
        @(negedge clk_i);
        check("t1_pvalid", x_p_valid_o, 32'd1);
        check("t1_rd",     x_p_rd_o, 32'd5);
        check("t1_data",   x_p_data_o, 32'd0);
        check("t1_err",    x_p_error_o, 32'd0);
        @(negedge clk_i);
        check("t1_popped", x_p_valid_o, 32'd0);

        // ---------------- 2: MADD operand gating ----------------
        req(enc(7'd0, 3'b000, 5'd7, 7'h0B), 32'd3, 32'd4, 32'd5);
        x_q_rs_valid_i = 3'b011;
        #1;
        check("t2_wait_ready",  x_q_ready_o, 32'd0);
        check("t2_wait_accept", x_k_accept_o, 32'd0);
        @(negedge clk_i);
        check("t2_hold_ready", x_q_ready_o, 32'd0);
        x_q_rs_valid_i = 3'b111;
        x_q_rd_clean_i = 1'b0;
        #1;
        check("t2_dirty_ready", x_q_ready_o, 32'd0);
        x_q_rd_clean_i = 1'b1;
        #1;
        check("t2_ready",  x_q_ready_o, 32'd1);
        check("t2_accept", x_k_accept_o, 32'd1);
        @(negedge clk_i);
        x_q_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("t2_pvalid", x_p_valid_o, 32'd1);
        check("t2_rd",     x_p_rd_o, 32'd7);
        check("t2_data",   x_p_data_o, 32'd17);
        @(negedge clk_i);
        check("t2_popped", x_p_valid_o, 32'd0);

        // ---------------- 3: rejects ----------------
        x_q_rs_valid_i = 3'b000;
        x_q_rd_clean_i = 1'b0;
        req(enc(7'd0, 3'b001, 5'd9, 7'h33), 32'd1, 32'd1, 32'd1);
        #1;
        check("t3_opc_ready",  x_q_ready_o, 32'd1);
        check("t3_opc_accept", x_k_accept_o, 32'd0);
        check("t3_opc_wb",     x_k_writeback_o, 32'd0);
        x_q_instr_data_i = enc(7'h20, 3'b001, 5'd9, 7'h0B);
        #1;
        check("t3_f7_ready",  x_q_ready_o, 32'd1);
        check("t3_f7_accept", x_k_accept_o, 32'd0);
        x_q_instr_data_i = enc(7'd0, 3'b100, 5'd9, 7'h0B);
        #1;
        check("t3_f3_accept", x_k_accept_o, 32'd0);
`ifndef X_ALU_ERR_EN
        x_q_instr_data_i = enc(7'd0, 3'b111, 5'd9, 7'h0B);
        #1;
        check("t3_f3_111_ready",  x_q_ready_o, 32'd1);
        check("t3_f3_111_accept", x_k_accept_o, 32'd0);
`endif
        @(negedge clk_i);
        x_q_valid_i    = 1'b0;
        x_q_rd_clean_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (x_p_valid_o) seen++;
        end
        check("t3_no_resp", seen, 32'd0);

        // ---------------- 4: backpressure and credits ----------------
        x_p_ready_i    = 1'b0;
        x_q_rs_valid_i = 3'b011;
        for (int i = 0; i < 4; i++) begin
            req(enc(7'd0, 3'b001, 5'(10 + i), 7'h0B), 32'(i), 32'd100, 32'd0);
            #1;
            check("t4_accept", x_k_accept_o, 32'd1);
            @(negedge clk_i);
        end
        req(enc(7'd0, 3'b001, 5'd14, 7'h0B), 32'd4, 32'd100, 32'd0);
        #1;
        check("t4_full_ready", x_q_ready_o, 32'd0);
        repeat (4) @(negedge clk_i);
        check("t4_held_ready", x_q_ready_o, 32'd0);
        check("t4_held_valid", x_p_valid_o, 32'd1);
        check("t4_held_rd",    x_p_rd_o, 32'd10);
        check("t4_held_data",  x_p_data_o, 32'd100);
        x_p_ready_i = 1'b1;
        #1;
        check("t4_r0_ready", x_q_ready_o, 32'd0);
        @(negedge clk_i);
        check("t4_r1_rd",     x_p_rd_o, 32'd11);
        check("t4_r1_data",   x_p_data_o, 32'd101);
        check("t4_r1_accept", x_k_accept_o, 32'd1);
        @(negedge clk_i);
        req(enc(7'd0, 3'b001, 5'd15, 7'h0B), 32'd5, 32'd100, 32'd0);
        #1;
        check("t4_r2_rd",     x_p_rd_o, 32'd12);
        check("t4_r2_data",   x_p_data_o, 32'd102);
        check("t4_r2_accept", x_k_accept_o, 32'd1);
        @(negedge clk_i);
        x_q_valid_i = 1'b0;
        #1;
        check("t4_r3_rd",   x_p_rd_o, 32'd13);
        check("t4_r3_data", x_p_data_o, 32'd103);
        @(negedge clk_i);
        check("t4_r4_valid", x_p_valid_o, 32'd1);
        check("t4_r4_rd",    x_p_rd_o, 32'd14);
        check("t4_r4_data",  x_p_data_o, 32'd104);
        @(negedge clk_i);
        check("t4_r5_rd",   x_p_rd_o, 32'd15);
        check("t4_r5_data", x_p_data_o, 32'd105);
        @(negedge clk_i);
        check("t4_drained", x_p_valid_o, 32'd0);

        // ---------------- 5: MIN / XOR back-to-back ----------------
        req(enc(7'd0, 3'b011, 5'd3, 7'h0B), 32'h8000_0000, 32'd7, 32'd0);
        #1;
        check("t5_min_accept", x_k_accept_o, 32'd1);
        @(negedge clk_i);
        req(enc(7'd0, 3'b010, 5'd4, 7'h0B), 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0);
        #1;
        check("t5_xor_accept", x_k_accept_o, 32'd1);
        @(negedge clk_i);
        req(enc(7'd0, 3'b011, 5'd6, 7'h0B), 32'd5, 32'hFFFF_FFFE, 32'd0);
        #1;
        check("t5_min2_accept", x_k_accept_o, 32'd1);
        @(negedge clk_i);
        x_q_valid_i = 1'b0;
        #1;
        check("t5_min_rd",   x_p_rd_o, 32'd3);
        check("t5_min_data", x_p_data_o, 32'h8000_0000);
        @(negedge clk_i);
        check("t5_xor_rd",   x_p_rd_o, 32'd4);
        check("t5_xor_data", x_p_data_o, 32'h5A5A_A5A5);
        @(negedge clk_i);
        check("t5_min2_rd",   x_p_rd_o, 32'd6);
        check("t5_min2_data", x_p_data_o, 32'hFFFF_FFFE);
        @(negedge clk_i);
        check("t5_drained", x_p_valid_o, 32'd0);

        // ---------------- 6: reset mid-operation ----------------
        x_p_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(enc(7'd0, 3'b001, 5'(1 + i), 7'h0B), 32'd1, 32'd1, 32'd0);
            @(negedge clk_i);
        end
        x_q_valid_i = 1'b0;
        @(negedge clk_i);
        check("t6_pre_valid", x_p_valid_o, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("t6_flush_valid", x_p_valid_o, 32'd0);
        check("t6_flush_rd",    x_p_rd_o, 32'd0);
        check("t6_flush_data",  x_p_data_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            req(enc(7'd0, 3'b001, 5'(20 + i), 7'h0B), 32'(7 + i), 32'd8, 32'd0);
            #1;
            check("t6_credit_accept", x_k_accept_o, 32'd1);
            @(negedge clk_i);
        end
        req(enc(7'd0, 3'b001, 5'd24, 7'h0B), 32'd0, 32'd0, 32'd0);
        #1;
        check("t6_full_ready", x_q_ready_o, 32'd0);
        x_q_valid_i = 1'b0;
        x_p_ready_i = 1'b1;
        #1;
        check("t6_first_rd",   x_p_rd_o, 32'd20);
        check("t6_first_data", x_p_data_o, 32'd15);
        @(negedge clk_i);
        check("t6_second_rd", x_p_rd_o, 32'd21);
        @(negedge clk_i);
        check("t6_third_rd", x_p_rd_o, 32'd22);
        @(negedge clk_i);
        check("t6_fourth_rd",   x_p_rd_o, 32'd23);
        check("t6_fourth_data", x_p_data_o, 32'd18);
        @(negedge clk_i);
        check("t6_drained", x_p_valid_o, 32'd0);

`ifdef X_ALU_ERR_EN
        // ---------------- error op ----------------
        x_q_rs_valid_i = 3'b000;
        req(enc(7'd0, 3'b111, 5'd25, 7'h0B), 32'h1234_5678, 32'd9, 32'd0);
        #1;
        check("err_accept", x_k_accept_o, 32'd1);
        check("err_wb",     x_k_writeback_o, 32'd1);
        @(negedge clk_i);
        x_q_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("err_valid", x_p_valid_o, 32'd1);
        check("err_rd",    x_p_rd_o, 32'd25);
        check("err_flag",  x_p_error_o, 32'd1);
        check("err_data",  x_p_data_o, 32'd0);
        @(negedge clk_i);
        check("err_drained", x_p_valid_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
